// File: rtl/video_pkg.sv
// Shared 640x480 video timing constants and the sprite-update FSM state type.
package video_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      CALC_X  = 2'd1,
      CALC_Y  = 2'd2,
      PUBLISH = 2'd3
   } state_t;

endpackage

// File: rtl/sprite_bounce_ctrl_if.sv
// Control/status bundle of the sprite bounce controller: the video timing side
// drives vsync/enable/speed, the controller publishes position and pulses.
interface sprite_bounce_ctrl_if;

   logic        vsync_n;
   logic        enable;
   logic [2:0]  speed;
   logic [9:0]  sprite_x;
   logic [9:0]  sprite_y;
   logic        frame_tick;
   logic        bounce_x;
   logic        bounce_y;
   logic [15:0] frame_cnt;

   modport master (
      output vsync_n, enable, speed,
      input  sprite_x, sprite_y, frame_tick, bounce_x, bounce_y, frame_cnt
   );

   modport slave (
      input  vsync_n, enable, speed,
      output sprite_x, sprite_y, frame_tick, bounce_x, bounce_y, frame_cnt
   );

endinterface

// File: rtl/axis_bounce.sv
// One-axis step: move pos by speed in the direction of dir, clamp at 0 / limit
// and reverse direction when the move would leave the range.
module axis_bounce (
   input  logic [9:0] i_pos,
   input  logic       i_dir,
   input  logic [2:0] i_speed,
   input  logic [9:0] i_limit,
   output logic [9:0] o_pos,
   output logic       o_dir,
   output logic       o_bounce
);

   logic signed [10:0] w_pos;
   logic signed [10:0] w_step;
   logic signed [10:0] w_lim;
   logic signed [10:0] w_nx;

   assign w_pos  = $signed({1'b0, i_pos});
   assign w_step = $signed({8'b0, i_speed});
   assign w_lim  = $signed({1'b0, i_limit});
   assign w_nx   = i_dir ? (w_pos - w_step) : (w_pos + w_step);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      o_pos    = w_nx[9:0];
      o_dir    = i_dir;
      o_bounce = 1'b0;
      // Landing exactly on a limit is a legal position, not a bounce.
      if (w_nx > w_lim) begin
         o_pos    = i_limit;
         o_dir    = ~i_dir;
         o_bounce = 1'b1;
      end else if (w_nx < 11'sd0) begin
         o_pos    = 10'd0;
         o_dir    = ~i_dir;
         o_bounce = 1'b1;
      end
   end

endmodule

// File: rtl/sprite_bounce_ctrl.sv
// Moves a sprite once per frame on the vsync_n falling edge, bouncing off the
// active-area edges, and publishes the new position with a one-cycle tick.
module sprite_bounce_ctrl #(
   parameter int H_ACTIVE = video_pkg::H_ACTIVE,
   parameter int V_ACTIVE = video_pkg::V_ACTIVE,
   parameter int SPR_W    = 16,
   parameter int SPR_H    = 16,
   parameter int X0       = 100,
   parameter int Y0       = 60
) (
   input  logic                 clk,
   input  logic                 reset,
   sprite_bounce_ctrl_if.slave  bus
);

   import video_pkg::*;

   localparam logic [9:0] X_LIM  = 10'(H_ACTIVE - SPR_W);
   localparam logic [9:0] Y_LIM  = 10'(V_ACTIVE - SPR_H);
   localparam logic [9:0] X_INIT = 10'(X0);
   localparam logic [9:0] Y_INIT = 10'(Y0);

   state_t      r_state;
   state_t      w_next_state;

   logic        r_vs_prev;
   logic [2:0]  r_speed;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic        r_dir_x;
   logic        r_dir_y;
   logic        r_bx;
   logic        r_by;

   logic [9:0]  r_sprite_x;
   logic [9:0]  r_sprite_y;
   logic        r_frame_tick;
   logic        r_bounce_x;
   logic        r_bounce_y;
   logic [15:0] r_frame_cnt;

   logic        w_vs_fall;
   logic        w_start;
   logic        w_calc_x;
   logic        w_calc_y;
   logic        w_publish;

   logic [9:0]  w_x_nx;
   logic        w_x_dir;
   logic        w_x_bounce;
   logic [9:0]  w_y_nx;
   logic        w_y_dir;
   logic        w_y_bounce;

   assign w_vs_fall = r_vs_prev & ~bus.vsync_n;

   axis_bounce u_axis_x (
      .i_pos    (r_x),
      .i_dir    (r_dir_x),
      .i_speed  (r_speed),
      .i_limit  (X_LIM),
      .o_pos    (w_x_nx),
      .o_dir    (w_x_dir),
      .o_bounce (w_x_bounce)
   );

   axis_bounce u_axis_y (
      .i_pos    (r_y),
      .i_dir    (r_dir_y),
      .i_speed  (r_speed),
      .i_limit  (Y_LIM),
      .o_pos    (w_y_nx),
      .o_dir    (w_y_dir),
      .o_bounce (w_y_bounce)
   );

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (reset) r_state <= WAIT_VS;
      else       r_state <= w_next_state;
   end

   // Edges seen outside WAIT_VS fall through here and are simply dropped.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         WAIT_VS: if (w_vs_fall && bus.enable) w_next_state = CALC_X;
         CALC_X:  w_next_state = CALC_Y;
         CALC_Y:  w_next_state = PUBLISH;
         PUBLISH: w_next_state = WAIT_VS;
         default: w_next_state = WAIT_VS;
      endcase
   end

   always_comb begin
      w_start   = 1'b0;
      w_calc_x  = 1'b0;
      w_calc_y  = 1'b0;
      w_publish = 1'b0;
      case (r_state)
         WAIT_VS: w_start   = w_vs_fall & bus.enable;
         CALC_X:  w_calc_x  = 1'b1;
         CALC_Y:  w_calc_y  = 1'b1;
         PUBLISH: w_publish = 1'b1;
         default: ;
      endcase
   end

   // Working registers: a reset mid-update restores them, so nothing partial survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vs_prev <= 1'b1;
         r_speed   <= 3'd0;
         r_x       <= X_INIT;
         r_y       <= Y_INIT;
         r_dir_x   <= 1'b0;
         r_dir_y   <= 1'b0;
         r_bx      <= 1'b0;
         r_by      <= 1'b0;
      end else begin
         r_vs_prev <= bus.vsync_n;
         if (w_start) begin
            r_speed <= bus.speed;
            r_bx    <= 1'b0;
            r_by    <= 1'b0;
         end
         if (w_calc_x) begin
            r_x     <= w_x_nx;
            r_dir_x <= w_x_dir;
            r_bx    <= w_x_bounce;
         end
         if (w_calc_y) begin
            r_y     <= w_y_nx;
            r_dir_y <= w_y_dir;
            r_by    <= w_y_bounce;
         end
      end
   end

   // Published outputs change only on the PUBLISH edge, together with the tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sprite_x   <= X_INIT;
         r_sprite_y   <= Y_INIT;
         r_frame_tick <= 1'b0;
         r_bounce_x   <= 1'b0;
         r_bounce_y   <= 1'b0;
         r_frame_cnt  <= 16'd0;
      end else begin
         r_frame_tick <= w_publish;
         r_bounce_x   <= w_publish & r_bx;
         r_bounce_y   <= w_publish & r_by;
         if (w_publish) begin
            r_sprite_x  <= r_x;
            r_sprite_y  <= r_y;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign bus.sprite_x   = r_sprite_x;
   assign bus.sprite_y   = r_sprite_y;
   assign bus.frame_tick = r_frame_tick;
   assign bus.bounce_x   = r_bounce_x;
   assign bus.bounce_y   = r_bounce_y;
   assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
// Self-checking bench: a frame-level behavioural model predicts every output each
// cycle; directed scenarios pin the model with hand-computed literals.
module tb_sprite_bounce_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sprite_bounce_ctrl_if bus_a ();
   sprite_bounce_ctrl_if bus_b ();

   // Main instance with default 640x480 geometry.
   sprite_bounce_ctrl dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_a)
   );

   // Tiny playfield (x limit 5, y limit 4) so corner bounces are reached quickly.
   sprite_bounce_ctrl #(
      .H_ACTIVE (21),
      .V_ACTIVE (20),
      .SPR_W    (16),
      .SPR_H    (16),
      .X0       (3),
      .Y0       (2)
   ) dut_s (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_b)
   );

   assign bus_b.vsync_n = bus_a.vsync_n;
   assign bus_b.enable  = bus_a.enable;
   assign bus_b.speed   = bus_a.speed;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;
   bit preload_req = 1'b0;
   int tick_cnt_a  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int x, y, dx, dy;
      int busy;
      int px, py, pdx, pdy;
      bit pbx, pby;
      bit vs_prev;
      int sx, sy, fc;
      bit tick, bx, by;
   } model_t;

   model_t ma, mb;

   function automatic model_t m_reset(input int x0, input int y0);
      model_t m;
      m = '{default: 0};
      m.x = x0; m.y = y0; m.sx = x0; m.sy = y0;
      m.vs_prev = 1'b1;
      return m;
   endfunction

   function automatic void move(input int pos, input int dir, input int spd, input int lim,
                                output int npos, output int ndir, output bit b);
      int n;
      n = (dir != 0) ? pos - spd : pos + spd;
      if (n > lim)    begin npos = lim; ndir = 1 - dir; b = 1'b1; end
      else if (n < 0) begin npos = 0;   ndir = 1 - dir; b = 1'b1; end
      else            begin npos = n;   ndir = dir;     b = 1'b0; end
   endfunction

   // A frame accepted on one edge is published three edges later; edges during
   // an update are ignored, so the whole result can be computed at acceptance.
   function automatic model_t m_step(input model_t mi, input bit vs_n, input bit en,
                                     input int spd, input int xlim, input int ylim);
      model_t m;
      m = mi;
      m.tick = 1'b0; m.bx = 1'b0; m.by = 1'b0;
      if (m.busy > 0) begin
         m.busy--;
         if (m.busy == 0) begin
            m.x = m.px; m.y = m.py; m.dx = m.pdx; m.dy = m.pdy;
            m.sx = m.px; m.sy = m.py;
            m.tick = 1'b1; m.bx = m.pbx; m.by = m.pby;
            m.fc = (m.fc + 1) % 65536;
         end
      end else if (m.vs_prev && !vs_n && en) begin
         move(m.x, m.dx, spd, xlim, m.px, m.pdx, m.pbx);
         move(m.y, m.dy, spd, ylim, m.py, m.pdy, m.pby);
         m.busy = 3;
      end
      m.vs_prev = vs_n;
      return m;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma = m_reset(100, 60);
         mb = m_reset(3, 2);
      end else begin
         ma = m_step(ma, bus_a.vsync_n, bus_a.enable, int'(bus_a.speed), 624, 464);
         mb = m_step(mb, bus_a.vsync_n, bus_a.enable, int'(bus_a.speed), 5, 4);
         if (preload_req) ma.fc = 65535;
      end
   end

   function automatic logic [63:0] pack_m(input model_t m);
      return 64'({10'(m.sx), 10'(m.sy), m.tick, m.bx, m.by, 16'(m.fc)});
   endfunction

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("model_a", 64'({bus_a.sprite_x, bus_a.sprite_y, bus_a.frame_tick,
                               bus_a.bounce_x, bus_a.bounce_y, bus_a.frame_cnt}), pack_m(ma));
         check("model_s", 64'({bus_b.sprite_x, bus_b.sprite_y, bus_b.frame_tick,
                               bus_b.bounce_x, bus_b.bounce_y, bus_b.frame_cnt}), pack_m(mb));
         if (bus_a.frame_tick) tick_cnt_a++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   // One enabled frame; returns cycles from the accepting edge to the tick (0 = none).
   task automatic frame(input logic [2:0] spd, output int lat);
      bus_a.speed   = spd;
      bus_a.enable  = 1'b1;
      bus_a.vsync_n = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (k == 1) bus_a.vsync_n = 1'b1;
         if (bus_a.frame_tick) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) check("tick_timeout", 64'(lat), 64'd4);
   endtask

   int lat;
   int snap;

   initial begin
      bus_a.vsync_n = 1'b1;
      bus_a.enable  = 1'b0;
      bus_a.speed   = 3'd0;
      do_reset();
      chk_en = 1'b1;

      // Reset values.
      check("rst_x",  64'(bus_a.sprite_x), 64'd100);
      check("rst_y",  64'(bus_a.sprite_y), 64'd60);
      check("rst_fc", 64'(bus_a.frame_cnt), 64'd0);
      check("rst_tick", 64'(bus_a.frame_tick), 64'd0);

      // First frame at speed 2.
      frame(3'd2, lat);
      check("lat",    64'(lat), 64'd4);
      check("f1_x",   64'(bus_a.sprite_x), 64'd102);
      check("f1_y",   64'(bus_a.sprite_y), 64'd62);
      check("f1_fc",  64'(bus_a.frame_cnt), 64'd1);
      step(1);
      check("f1_tick_width", 64'(bus_a.frame_tick), 64'd0);

      // Corner: small instance reaches (2,1) moving -,- then hits both zero walls.
      do_reset();
      frame(3'd3, lat);
      check("s1_bx", 64'({bus_b.sprite_x, bus_b.bounce_x, bus_b.bounce_y}), {53'd0, 10'd5, 1'b1, 1'b1});
      frame(3'd3, lat);
      check("s2_xy", 64'({bus_b.sprite_x, bus_b.sprite_y}), {44'd0, 10'd2, 10'd1});
      frame(3'd3, lat);
      check("s3_xy", 64'({bus_b.sprite_x, bus_b.sprite_y}), 64'd0);
      check("s3_bxy", 64'({bus_b.bounce_x, bus_b.bounce_y}), 64'd3);

      // Speed 0 still publishes with no movement or bounce.
      frame(3'd0, lat);
      check("spd0_x", 64'({bus_b.sprite_x, bus_b.frame_tick, bus_b.bounce_x}), {53'd0, 10'd0, 1'b1, 1'b0});

      // enable low across five vsync edges.
      do_reset();
      snap = tick_cnt_a;
      bus_a.enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus_a.vsync_n = 1'b0;
         step(2);
         bus_a.vsync_n = 1'b1;
         step(3);
      end
      check("dis_ticks", 64'(tick_cnt_a - snap), 64'd0);
      check("dis_state", 64'({bus_a.sprite_x, bus_a.frame_cnt}), {38'd0, 10'd100, 16'd0});

      // Second edge two cycles after the first is ignored.
      snap = tick_cnt_a;
      bus_a.enable = 1'b1;
      bus_a.speed = 3'd2;
      bus_a.vsync_n = 1'b0;
      step(1);
      bus_a.vsync_n = 1'b1;
      step(1);
      bus_a.vsync_n = 1'b0;
      step(1);
      bus_a.vsync_n = 1'b1;
      step(10);
      check("dbl_edge_ticks", 64'(tick_cnt_a - snap), 64'd1);
      check("dbl_edge_x", 64'(bus_a.sprite_x), 64'd102);

      // Reset during CALC_Y discards the update.
      bus_a.vsync_n = 1'b0;
      step(1);
      bus_a.vsync_n = 1'b1;
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      snap = tick_cnt_a;
      step(8);
      check("rst_mid_ticks", 64'(tick_cnt_a - snap), 64'd0);
      check("rst_mid_xy", 64'({bus_a.sprite_x, bus_a.sprite_y}), {44'd0, 10'd100, 10'd60});

      // Walk X to 622, then bounce off the right wall.
      do_reset();
      for (int i = 0; i < 261; i++) frame(3'd2, lat);
      check("walk_x", 64'(bus_a.sprite_x), 64'd622);
      frame(3'd4, lat);
      check("rw_x",  64'({bus_a.sprite_x, bus_a.bounce_x}), {53'd0, 10'd624, 1'b1});
      frame(3'd4, lat);
      check("rw_x2", 64'({bus_a.sprite_x, bus_a.bounce_x}), {53'd0, 10'd620, 1'b0});

      // frame_cnt wrap.
      @(negedge clk);
      #1;
      force dut.r_frame_cnt = 16'hFFFF;
      preload_req = 1'b1;
      @(posedge clk);
      #1;
      release dut.r_frame_cnt;
      preload_req = 1'b0;
      check("preload_fc", 64'(bus_a.frame_cnt), 64'd65535);
      frame(3'd1, lat);
      check("wrap_fc", 64'(bus_a.frame_cnt), 64'd0);

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 4000; i++) begin
         bus_a.vsync_n = 1'($urandom_range(0, 1));
         bus_a.enable  = ($urandom_range(0, 9) < 8);
         bus_a.speed   = 3'($urandom_range(0, 7));
         rst           = ($urandom_range(0, 499) == 0);
         step(1);
      end
      rst = 1'b0;
      bus_a.vsync_n = 1'b1;
      step(6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_bounce_ctrl.md
SPRITE_BOUNCE_CTRL -- requirements
Module: sprite_bounce_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 Parameter SPR_W, default 16: sprite width in pixels.
REQ-004 Parameter SPR_H, default 16: sprite height in lines.
REQ-005 Parameter X0, default 100: reset X position.
REQ-006 Parameter Y0, default 60: reset Y position.
REQ-007 clk  in  1: pixel clock, the single clock; all logic is on its rising edge.
REQ-008 reset  in  1: reset, asynchronous, active-high.
REQ-009 vsync_n  in  1: active-low vertical sync from the video timing generator; asynchronous to nothing, already in the clk domain.
REQ-010 enable  in  1: high = motion runs; low = position frozen.
REQ-011 speed  in  3: pixels moved per frame on each axis; 0 = stopped.
REQ-012 sprite_x  out  10: published left edge of the sprite.
REQ-013 sprite_y  out  10: published top edge of the sprite.
REQ-014 frame_tick  out  1: one-cycle pulse when a new position is published.
REQ-015 bounce_x  out  1: one-cycle pulse, coincident with frame_tick, when X reversed this frame.
REQ-016 bounce_y  out  1: same for Y.
REQ-017 frame_cnt  out  16: count of published updates, wraps 65535 -> 0.

Function
REQ-018 The FSM SHALL have states WAIT_VS, CALC_X, CALC_Y, PUBLISH; reset state WAIT_VS.
REQ-019 WAIT_VS SHALL detect a falling edge of vsync_n (registered previous value 1, current 0) and go to CALC_X only if enable is 1 that cycle; otherwise stay.
REQ-020 speed SHALL be sampled on the edge-detect cycle and held for the whole update.
REQ-021 CALC_X SHALL compute nx = x +/- speed in 11-bit signed arithmetic per direction flag dir_x (0 = +, 1 = -).
REQ-022 If nx > H_ACTIVE-SPR_W, X SHALL clamp to H_ACTIVE-SPR_W and dir_x SHALL toggle; if nx < 0, X SHALL clamp to 0 and dir_x toggle; else X = nx.
REQ-023 A position exactly equal to a limit SHALL NOT bounce; it bounces on the next move that would exceed it.
REQ-024 CALC_Y SHALL apply REQ-021/022 to Y, dir_y, limit V_ACTIVE-SPR_H.
REQ-025 Both axes bouncing in one frame SHALL assert bounce_x and bounce_y in the same cycle.
REQ-026 PUBLISH SHALL copy working X/Y to sprite_x/sprite_y in the same cycle, assert frame_tick, increment frame_cnt, then return to WAIT_VS; sprite_x/sprite_y SHALL never change at any other time.
REQ-027 Latency: sprite_x/sprite_y update 4 clk cycles after the cycle vsync_n is first sampled low.
REQ-028 vsync_n edges arriving while not in WAIT_VS SHALL be ignored (not queued).
REQ-029 speed = 0 with enable = 1 SHALL still publish (frame_tick, frame_cnt++) with unchanged position and no bounce.
REQ-030 enable deasserted mid-update SHALL NOT abort the update in progress.

Reset
REQ-031 On reset: state WAIT_VS, working and published X = X0, Y = Y0, dir_x = dir_y = 0, frame_cnt = 0, frame_tick = bounce_x = bounce_y = 0, edge-detect register = 1.
REQ-032 Reset asserted mid-update SHALL discard the update; nothing partial is published.

Structure
REQ-033 Shared package video_pkg SHALL hold the 640x480 timing constants (H_ACTIVE, V_ACTIVE) and the FSM state typedef; sprite_bounce_ctrl imports them.
REQ-034 One sub-module, axis_bounce, SHALL implement REQ-021/022 combinationally for one axis (inputs pos, dir, speed, limit; outputs next pos, next dir, bounce); instantiated twice or time-shared.

Verification
REQ-035 Reset, enable=1, speed=2, one vsync_n falling edge -> after 4 cycles sprite_x=102, sprite_y=62, frame_tick=1 for one cycle, frame_cnt=1.
REQ-036 X=622, dir_x=+, speed=4 -> sprite_x=624, bounce_x=1, dir_x=-; next frame sprite_x=620.
REQ-037 X=2, Y=1, both dirs -, speed=3 -> sprite_x=0, sprite_y=0, bounce_x and bounce_y both pulse same cycle.
REQ-038 enable=0 across 5 vsync edges -> no frame_tick, outputs unchanged, frame_cnt unchanged.
REQ-039 Second vsync_n falling edge injected 2 cycles after the first -> exactly one publish; reset pulsed during CALC_Y -> outputs return to X0/Y0, no frame_tick.
REQ-040 frame_cnt preloaded to 65535 via 65535 frames (or forced) -> next publish gives 0.
